// File: rtl/regfile_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ requesters onto a single-port-write,
// dual-port-read register file. Optional grant locking is enabled by REGFILE_ARB_LOCK_EN.
module regfile_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_wa,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_w,
    input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_raa,
    input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_rab,
    input  logic [NUM_REQ-1:0]             req_lock,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATAWIDTH-1:0]           rsp_a,
    output logic [DATAWIDTH-1:0]           rsp_b,
    output logic [DATAWIDTH-1:0]           W,
    output logic                           Wen,
    output logic [ADDRWIDTH-1:0]           WA,
    output logic [ADDRWIDTH-1:0]           RAA,
    output logic [ADDRWIDTH-1:0]           RAB,
    input  logic [DATAWIDTH-1:0]           A,
    input  logic [DATAWIDTH-1:0]           B
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0] rsp_a_q, rsp_a_d;
    logic [DATAWIDTH-1:0] rsp_b_q, rsp_b_d;

    logic [NUM_REQ-1:0]   elig_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic                 any_s;
    logic                 rd_s;
    logic                 sel_wr_s;
    logic [ADDRWIDTH-1:0] sel_wa_s, sel_raa_s, sel_rab_s;
    logic [DATAWIDTH-1:0] sel_w_s;
    logic [PTR_W-1:0]     sel_nxt_s;

`ifdef REGFILE_ARB_LOCK_EN
    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]       lock_st_q, lock_st_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] sel_idx_s;
    logic             sel_lock_s;
`else
    logic             lock_unused_s;
    assign lock_unused_s = ^req_lock;
`endif

    // Eligible requesters: everyone, or only the owner while a lock is held.
    always_comb begin
        elig_s = req_valid;
`ifdef REGFILE_ARB_LOCK_EN
        if (lock_st_q == ST_LOCKED) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                elig_s[i] = req_valid[i] & (owner_q == PTR_W'(i));
            end
        end else begin
            elig_s = req_valid;
        end
`endif
    end

    // Round-robin search starting at ptr; reset forces the grant off immediately.
    always_comb begin
        logic found_v;
        gnt_s   = '0;
        found_v = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found_v && elig_s[i] && (((int'(ptr_q) + k) % NUM_REQ) == i)) begin
                    gnt_s[i] = 1'b1;
                    found_v  = 1'b1;
                end else begin
                    gnt_s[i] = gnt_s[i];
                end
            end
        end
        if (!rst_n) begin
            gnt_s = '0;
        end else begin
            gnt_s = gnt_s;
        end
    end

    // Select the granted requester's payload.
    always_comb begin
        sel_wr_s  = 1'b0;
        sel_wa_s  = '0;
        sel_w_s   = '0;
        sel_raa_s = '0;
        sel_rab_s = '0;
        sel_nxt_s = ptr_q;
`ifdef REGFILE_ARB_LOCK_EN
        sel_idx_s  = '0;
        sel_lock_s = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                sel_wr_s  = req_wr[i];
                sel_wa_s  = req_wa[i*ADDRWIDTH +: ADDRWIDTH];
                sel_w_s   = req_w[i*DATAWIDTH +: DATAWIDTH];
                sel_raa_s = req_raa[i*ADDRWIDTH +: ADDRWIDTH];
                sel_rab_s = req_rab[i*ADDRWIDTH +: ADDRWIDTH];
                sel_nxt_s = PTR_W'((i + 1) % NUM_REQ);
`ifdef REGFILE_ARB_LOCK_EN
                sel_idx_s  = PTR_W'(i);
                sel_lock_s = req_lock[i];
`endif
            end else begin
                sel_wr_s = sel_wr_s;
            end
        end
    end

    assign any_s     = |gnt_s;
    assign rd_s      = any_s & ~sel_wr_s;
    assign req_ready = gnt_s;

    // Regfile-facing ports; idle values are zero so the bus is quiet between ops.
    always_comb begin
        Wen = any_s & sel_wr_s;
        if (Wen) begin
            WA = sel_wa_s;
            W  = sel_w_s;
        end else begin
            WA = '0;
            W  = '0;
        end
        if (rd_s) begin
            RAA = sel_raa_s;
            RAB = sel_rab_s;
        end else begin
            RAA = '0;
            RAB = '0;
        end
    end

    // Next-state for pointer, response and lock.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rd_s ? gnt_s : '0;
        rsp_a_d     = rd_s ? A : rsp_a_q;
        rsp_b_d     = rd_s ? B : rsp_b_q;
`ifdef REGFILE_ARB_LOCK_EN
        lock_st_d = lock_st_q;
        owner_d   = owner_q;
        case (lock_st_q)
            ST_UNLOCKED: begin
                if (any_s && sel_lock_s) begin
                    lock_st_d = ST_LOCKED;
                    owner_d   = sel_idx_s;
                end else begin
                    lock_st_d = ST_UNLOCKED;
                end
                if (any_s) begin
                    ptr_d = sel_nxt_s;
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ST_LOCKED: begin
                // Pointer stays frozen until the owner releases the lock.
                if (any_s && !sel_lock_s) begin
                    lock_st_d = ST_UNLOCKED;
                    ptr_d     = sel_nxt_s;
                end else begin
                    lock_st_d = ST_LOCKED;
                end
            end
            default: begin
                lock_st_d = ST_UNLOCKED;
                owner_d   = '0;
            end
        endcase
`else
        if (any_s) begin
            ptr_d = sel_nxt_s;
        end else begin
            ptr_d = ptr_q;
        end
`endif
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
`ifdef REGFILE_ARB_LOCK_EN
            lock_st_q   <= ST_UNLOCKED;
            owner_q     <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
`ifdef REGFILE_ARB_LOCK_EN
            lock_st_q   <= lock_st_d;
            owner_q     <= owner_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters, range 2..8.
REQ-002 Parameter DATAWIDTH, default 8: register data width.
REQ-003 Parameter ADDRWIDTH, default 4: register address width (16 registers).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester grant; the operation is accepted when valid and ready are both high.
- req_wr  in  NUM_REQ  1 = write operation, 0 = read-pair operation.
- req_wa  in  NUM_REQ*ADDRWIDTH  write address per requester.
- req_w  in  NUM_REQ*DATAWIDTH  write data per requester.
- req_raa, req_rab  in  NUM_REQ*ADDRWIDTH each  read addresses per requester.
- req_lock  in  NUM_REQ  hold the grant (REGFILE_ARB_LOCK_EN only; ignored otherwise).
- rsp_valid  out  NUM_REQ  one-hot read response owner.
- rsp_a, rsp_b  out  DATAWIDTH each  read data.
- W  out  DATAWIDTH  regfile write data.
- Wen  out  1  regfile write enable.
- WA  out  ADDRWIDTH  regfile write address.
- RAA, RAB  out  ADDRWIDTH each  regfile read addresses.
- A, B  in  DATAWIDTH each  regfile combinational read data.

Function
REQ-005 The block SHALL grant at most one requester per cycle: req_ready is one-hot or zero, combinational from req_valid and the priority pointer, and the grant never depends on req_ready.
REQ-006 Round-robin: the search SHALL start at ptr; after an accepted op by requester i, ptr becomes (i+1) mod NUM_REQ; ptr is unchanged when no op is accepted.
REQ-007 Write accept: Wen=1, WA=req_wa[i], W=req_w[i] in the same cycle; the regfile updates at that edge.
REQ-008 Write idle: Wen SHALL be 0 whenever no write is accepted; W/WA are don't-care but driven to 0.
REQ-009 Read accept: RAA/RAB SHALL be driven from requester i in the same cycle, A/B registered into rsp_a/rsp_b, and rsp_valid[i]=1 for exactly the next cycle (latency 1).
REQ-010 With no read accepted, RAA/RAB SHALL be 0, rsp_valid=0, and rsp_a/rsp_b SHALL hold their last values.
REQ-011 A read of an address written in the previous cycle SHALL return the new value; there is no same-cycle read/write conflict because only one op is granted per cycle.
REQ-012 A requester SHALL keep valid and its payload stable until accepted; dropping valid early is permitted, and no op is then performed.
REQ-013 Back-to-back reads from different requesters SHALL produce consecutive single-cycle rsp_valid pulses with correct owners.

Reset
REQ-014 Asserting rst_n low SHALL immediately clear ptr to 0, rsp_valid to 0, rsp_a/rsp_b to 0 and lock state to UNLOCKED, and force Wen to 0.
REQ-015 A read accepted in the cycle reset asserts SHALL produce no response; a write in progress when reset asserts is not guaranteed to complete.
REQ-016 The first grant after deassertion SHALL search from requester 0.

Configuration
REQ-017 Macro REGFILE_ARB_LOCK_EN defined: a two-state FSM UNLOCKED/LOCKED(owner) is implemented.
REQ-018 UNLOCKED -> LOCKED(i) on an accept by i with req_lock[i]=1.
REQ-019 In LOCKED(i) only i may be granted, and ptr is frozen.
REQ-020 LOCKED(i) -> UNLOCKED on an accept by i with req_lock[i]=0, after which ptr becomes i+1.
REQ-021 Macro undefined: req_lock is ignored and the block is purely round-robin.

Verification
REQ-022 Reset, then req0 writes 0xA5 to reg 3 -> Wen=1, WA=3, W=0xA5 in the same cycle; a later read by req1 of RAA=3 -> rsp_a=0xA5 one cycle after acceptance, rsp_valid=2'b10.
REQ-023 Both requesters hold valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1.
REQ-024 Write 0x3C to reg 15 at cycle n and read reg 15 at cycle n+1 -> rsp_a=0x3C at n+2.
REQ-025 Assert rst_n low mid-read -> rsp_valid=0, Wen=0 immediately; after release, req1 and req0 both valid -> req0 granted first.
REQ-026 With REGFILE_ARB_LOCK_EN, req1 locks and req0 is valid -> req1 is granted for 4 cycles, req0 is stalled, and after req1 unlocks req0 is granted next.
